// File: rtl/i2s_audio_rx.sv
// -----------------------------------------------------------------------------
// i2s_audio_rx
//
// I2S receiver. This block deserializes an oversampled I2S stream into one
// left/right pair of parallel samples per frame. The i2s_* inputs are
// asynchronous to `clock`. Each one passes through a 2-FF synchronizer, and
// SCLK rising edges are then detected in the clock domain. Each channel
// captures WIDTH bits, MSB first, left-justified in the slot. The first bit
// after every LRCK change is the I2S delay slot and is discarded.
//
// Optional build macro:
//   I2S_RX_FRAME_CHECK_EN - builds a per-slot SCLK counter. A slot length
//                           other than SLOT sets the sticky frame_error.
//                           When the macro is undefined, frame_error is tied 0.
//
// Ports:
//   clock        in   block clock, >= 4x i2s_sclk
//   reset        in   synchronous, active-high
//   i2s_sclk     in   serial bit clock (async), data sampled on its rise
//   i2s_lrck     in   word select (async), 0 = left, 1 = right
//   i2s_sdata    in   serial data (async)
//   sample_left  out  last complete left word (two's complement)
//   sample_right out  last complete right word (two's complement)
//   sample_valid out  one-cycle pulse when a new pair is presented
//   frame_error  out  sticky slot-length error (frame-check build only)
// -----------------------------------------------------------------------------
module i2s_audio_rx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i2s_sclk,
  input  logic             i2s_lrck,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  output logic             frame_error
);

  localparam int                IDX_W    = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and SCLK edge detect
  // ---------------------------------------------------------------------------
  logic sclk_m, sclk_s, sclk_d;
  logic lrck_m, lrck_s;
  logic sdata_m, sdata_s;

  // NOTE: every flop is written with <=, so all of them sample the values
  // from before the edge. This is what makes the back-to-back chain below a
  // real 2-stage synchronizer and not a single wire.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_m  <= 1'b0;
      sclk_s  <= 1'b0;
      sclk_d  <= 1'b0;
      lrck_m  <= 1'b0;
      lrck_s  <= 1'b0;
      sdata_m <= 1'b0;
      sdata_s <= 1'b0;
    end else begin
      sclk_m  <= i2s_sclk;
      sclk_s  <= sclk_m;
      sclk_d  <= sclk_s;
      lrck_m  <= i2s_lrck;
      lrck_s  <= lrck_m;
      sdata_m <= i2s_sdata;
      sdata_s <= sdata_m;
    end
  end

  logic rise;
  logic ws_prev;
  logic ws_change;

  assign rise      = sclk_s & ~sclk_d;
  assign ws_change = (lrck_s != ws_prev);

  // ---------------------------------------------------------------------------
  // Bit capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift;
  logic [IDX_W-1:0] bit_idx;
  chan_t            chan;
  logic             word_done;   // shift holds a completed word this cycle

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_prev   <= 1'b0;
      shift     <= '0;
      bit_idx   <= '0;
      chan      <= CH_LEFT;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (rise) begin
        ws_prev <= lrck_s;
        if (ws_change) begin
          // This bit is the delay slot (or the previous word's LSB). Any
          // partial word in progress is abandoned.
          bit_idx <= '0;
          chan    <= chan_t'(lrck_s);
        end else if (bit_idx < IDX_FULL) begin
          shift     <= {shift[WIDTH-2:0], sdata_s};
          bit_idx   <= bit_idx + 1'b1;
          word_done <= (bit_idx == IDX_LAST);
        end
        // Otherwise the bit is slot padding; bit_idx stays saturated at WIDTH.
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word pairing and output register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] left_hold;
  logic             have_left;

  always_ff @(posedge clock) begin
    if (reset) begin
      left_hold    <= '0;
      have_left    <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // SCLK rises are at least 4 clocks apart, so chan cannot change
      // between the rise that completed the word and this cycle.
      if (word_done) begin
        if (chan == CH_LEFT) begin
          left_hold <= shift;
          have_left <= 1'b1;
        end else if (have_left) begin
          sample_left  <= left_hold;
          sample_right <= shift;
          sample_valid <= 1'b1;
          have_left    <= 1'b0;
        end
        // A right word with no left word pending is dropped. This happens
        // at startup or after a left word was lost.
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional slot-length check
  // ---------------------------------------------------------------------------
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam int               CNT_W    = $clog2(SLOT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT);

  logic [CNT_W-1:0] slot_cnt;
  logic             seen_ws;   // the first LRCK change after reset ends a slot of unknown length

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt    <= '0;
      seen_ws     <= 1'b0;
      frame_error <= 1'b0;
    end else if (rise) begin
      if (ws_change) begin
        slot_cnt <= CNT_W'(1);
        seen_ws  <= 1'b1;
        if (seen_ws && (slot_cnt != CNT_SLOT)) begin
          frame_error <= 1'b1;
        end
      end else if (slot_cnt != '1) begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end
`else
  assign frame_error = 1'b0;
`endif

endmodule
